keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scans a 4x4 matrix keypad on the poncho board and delivers debounced key codes as 4-bit hex values. It is the input-side counterpart of the multiplexed 7-segment display path: it drives the columns one at a time and reads the rows, where the display path drives the digits and writes the segments. Its `key_hex` and `key_valid` outputs feed user logic directly, for example a pulse adder whose result goes back to the display driver.

## Interface
- `PRESCALER_BITS`, default 14: column dwell time is 2^PRESCALER_BITS clk cycles. Minimum value is 2.
- `DEBOUNCE_SCANS`, default 4: number of consecutive identical full frames required to accept a press or a release. Range is 2..15.
- `clk`  in  1: single clock domain.
- `rst`  in  1: synchronous, active-high reset.
- `row_in`  in  4: keypad rows. Active-low, externally pulled up, asynchronous to `clk`.
- `col_out`  out  4: keypad columns. Active-low and one-cold; exactly one bit is 0 at all times.
- `key_hex`  out  4: code of the last accepted key, {row_idx[1:0], col_idx[1:0]}. It holds its value until the next accepted press.
- `key_valid`  out  1: one-cycle pulse when a new press is accepted.
- `key_down`  out  1: high while the accepted key is considered held.

## Operation
- **Synchronizer:** `row_in` passes through a 2-FF synchronizer. The synchronizer flops reset to 4'b1111.
- **Prescaler:** a free-running PRESCALER_BITS-bit counter. `tick` is high in the cycle when the counter equals all-ones.
- **Column scan:**
  - `col_idx` runs 0..3 and `col_out` = ~(1 << `col_idx`).
  - On `tick`, ~`row_sync` is stored into the 16-bit frame snapshot at bits [`col_idx`*4 +: 4]. Bit index `r` within that nibble is the row.
  - `col_idx` then increments modulo 4, so `col_out` changes on the following cycle.
- **Frame done:** a `tick` taken with `col_idx` == 3 registers `frame_done` high for one cycle, carrying the complete snapshot.
- **Frame classification:** each frame is NONE (0 keys), SINGLE(code) (exactly 1 key), or MULTI (2 or more keys).
- **Debounce FSM:** evaluated only on `frame_done` cycles. `cnt` is 4 bits. `cand` is the candidate code.
  - IDLE:
    - SINGLE(k) → DEBOUNCE, `cand`=k, `cnt`=1.
    - NONE or MULTI → stay in IDLE.
  - DEBOUNCE:
    - SINGLE(`cand`) → `cnt`++. When `cnt` reaches DEBOUNCE_SCANS: go to PRESSED, set `key_hex`=`cand`, set `key_down`=1, pulse `key_valid`.
    - SINGLE(other) → stay in DEBOUNCE, `cand`=other, `cnt`=1.
    - NONE or MULTI → IDLE, `cnt`=0.
  - PRESSED:
    - NONE → RELEASE, `cnt`=1.
    - SINGLE or MULTI of any key → stay in PRESSED. A second key never produces a pulse until a full release.
  - RELEASE:
    - NONE → `cnt`++. When `cnt` reaches DEBOUNCE_SCANS: go to IDLE, set `key_down`=0.
    - Any key → back to PRESSED, `cnt`=0. No new `key_valid`.
- **Reset values** (all outputs registered):
  - `col_out`=4'b1110, `key_hex`=0, `key_valid`=0, `key_down`=0.
  - State=IDLE; prescaler, `col_idx`, `cnt`, and snapshot all 0.
- **Reset mid-operation:** reset overrides everything in its cycle. Scanning restarts at column 0 and no pending press survives.

## Timing
- Column dwell is 2^PRESCALER_BITS cycles. A frame is 4·2^PRESCALER_BITS cycles.
  - At 12 MHz with defaults: dwell is about 1.37 ms and a frame about 5.46 ms.
  - Press acceptance needs 4 frames, about 21.8 ms.
- Row sampling happens 2^PRESCALER_BITS−1 cycles after the column change. This gives settle margin for the 2-cycle synchronizer.
- `frame_done` occurs 1 cycle after the column-3 `tick`.
- `key_valid` and `key_down` change 1 cycle after the deciding `frame_done`. `key_hex` updates in that same cycle.
- `key_valid` is never high in two consecutive cycles, and is never high while `key_down` was already 1.
- Worst-case press-to-`key_valid` latency is (DEBOUNCE_SCANS+1) frames + 4 cycles.

## Test plan
Bench settings: PRESCALER_BITS=2, DEBOUNCE_SCANS=3. The keypad model pulls `row_in[r]` low iff key(r,c) is pressed and `col_out[c]`==0.
- **Reset and scan:** assert `rst` for 3 cycles. Then `col_out`=1110 and all key outputs are 0. `col_out` then rotates 1110→1101→1011→0111→1110, changing every 4 cycles.
- **Single press:** hold key row 2, col 1 from an idle state. Exactly one `key_valid` pulse with `key_hex`=4'h9, after 3 full frames. `key_down`=1. No further pulse over 10 more frames.
- **Bounce:** press for 1 frame, release for 1 frame, press again and hold. No `key_valid` until 3 consecutive SINGLE(9) frames after the second press.
- **Two keys:** press keys 0 and 5 together. No pulse. Release key 0 with 5 still held: `key_valid` with `key_hex`=4'h5 after 3 frames.
- **Release:** key held, then release. `key_down` falls after 3 NONE frames with no pulse. A 1-frame release glitch followed by a re-press keeps `key_down`=1 and produces no new `key_valid`.
- **Reset mid-debounce:** assert `rst` while in DEBOUNCE with `cnt`=2. The next cycle shows reset values and `col_out`=1110. With the key still held, acceptance requires 3 fresh frames.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner
//
// Scans a 4x4 active-low matrix keypad one column at a time, assembles a
// full 16-bit frame snapshot, and debounces it into accepted key codes.
//
// Parameters:
//   PRESCALER_BITS - column dwell is 2^PRESCALER_BITS clk cycles (>= 2)
//   DEBOUNCE_SCANS - consecutive identical frames to accept press/release (2..15)
//
// Ports:
//   clk       - single clock domain
//   rst       - synchronous, active-high reset
//   row_in    - keypad rows, active-low, asynchronous to clk
//   col_out   - keypad columns, active-low one-cold drive
//   key_hex   - last accepted key code {row_idx, col_idx}
//   key_valid - one-cycle pulse when a new press is accepted
//   key_down  - high while the accepted key is held
module keypad_scanner #(
    parameter int PRESCALER_BITS = 14,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_hex,
    output logic       key_valid,
    output logic       key_down
);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } state_t;

    localparam logic [3:0] DEB_LIMIT = 4'(DEBOUNCE_SCANS);
    localparam logic [PRESCALER_BITS-1:0] PRESC_ONE = {{(PRESCALER_BITS-1){1'b0}}, 1'b1};

    logic [3:0]                row_meta_q, row_meta_d;
    logic [3:0]                row_sync_q, row_sync_d;
    logic [PRESCALER_BITS-1:0] presc_q, presc_d;
    logic [1:0]                col_idx_q, col_idx_d;
    logic [3:0]                col_out_q, col_out_d;
    logic [15:0]               snapshot_q, snapshot_d;
    logic                      frame_done_q, frame_done_d;
    state_t                    state_q, state_d;
    logic [3:0]                cnt_q, cnt_d;
    logic [3:0]                cand_q, cand_d;
    logic [3:0]                key_hex_q, key_hex_d;
    logic                      key_valid_q, key_valid_d;
    logic                      key_down_q, key_down_d;

    logic                      tick;
    logic [4:0]                key_count;
    logic [3:0]                key_idx;
    logic [3:0]                frame_code;
    logic                      frame_none;
    logic                      frame_single;
    logic [3:0]                cnt_inc;

    assign tick = &presc_q;

    // Synchronizer, prescaler and column scan. The snapshot nibble for the
    // current column is written on the tick that also advances the column,
    // so when frame_done is seen the snapshot already holds column 3.
    always_comb begin
        row_meta_d   = row_in;
        row_sync_d   = row_meta_q;
        presc_d      = presc_q + PRESC_ONE;
        col_idx_d    = col_idx_q;
        snapshot_d   = snapshot_q;
        frame_done_d = 1'b0;
        if (tick) begin
            snapshot_d[{col_idx_q, 2'b00} +: 4] = ~row_sync_q;
            col_idx_d    = col_idx_q + 2'd1;
            frame_done_d = (col_idx_q == 2'd3);
        end
        col_out_d = ~(4'b0001 << col_idx_d);
    end

    // Frame classification. Snapshot bit index is col*4 + row, so the key
    // code {row, col} is the index with its two halves swapped.
    always_comb begin
        key_count = 5'd0;
        key_idx   = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (snapshot_q[i]) begin
                key_count = key_count + 5'd1;
                key_idx   = 4'(i);
            end
        end
        frame_code   = {key_idx[1:0], key_idx[3:2]};
        frame_none   = (key_count == 5'd0);
        frame_single = (key_count == 5'd1);
    end

    assign cnt_inc = cnt_q + 4'd1;

    // Debounce FSM, advanced only on frame_done cycles. A MULTI frame in
    // PRESSED/RELEASE counts as "a key is down" so a second key can never
    // produce a pulse before a full release.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        key_hex_d   = key_hex_q;
        key_valid_d = 1'b0;
        key_down_d  = key_down_q;
        if (frame_done_q) begin
            case (state_q)
                IDLE: begin
                    if (frame_single) begin
                        state_d = DEBOUNCE;
                        cand_d  = frame_code;
                        cnt_d   = 4'd1;
                    end
                end
                DEBOUNCE: begin
                    if (frame_single && (frame_code == cand_q)) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DEB_LIMIT) begin
                            state_d     = PRESSED;
                            cnt_d       = 4'd0;
                            key_hex_d   = cand_q;
                            key_down_d  = 1'b1;
                            key_valid_d = 1'b1;
                        end
                    end else if (frame_single) begin
                        cand_d = frame_code;
                        cnt_d  = 4'd1;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = 4'd0;
                    end
                end
                PRESSED: begin
                    if (frame_none) begin
                        state_d = RELEASE;
                        cnt_d   = 4'd1;
                    end
                end
                RELEASE: begin
                    if (frame_none) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DEB_LIMIT) begin
                            state_d    = IDLE;
                            cnt_d      = 4'd0;
                            key_down_d = 1'b0;
                        end
                    end else begin
                        state_d = PRESSED;
                        cnt_d   = 4'd0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta_q   <= 4'b1111;
            row_sync_q   <= 4'b1111;
            presc_q      <= '0;
            col_idx_q    <= 2'd0;
            col_out_q    <= 4'b1110;
            snapshot_q   <= 16'h0000;
            frame_done_q <= 1'b0;
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            cand_q       <= 4'd0;
            key_hex_q    <= 4'd0;
            key_valid_q  <= 1'b0;
            key_down_q   <= 1'b0;
        end else begin
            row_meta_q   <= row_meta_d;
            row_sync_q   <= row_sync_d;
            presc_q      <= presc_d;
            col_idx_q    <= col_idx_d;
            col_out_q    <= col_out_d;
            snapshot_q   <= snapshot_d;
            frame_done_q <= frame_done_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cand_q       <= cand_d;
            key_hex_q    <= key_hex_d;
            key_valid_q  <= key_valid_d;
            key_down_q   <= key_down_d;
        end
    end

    assign col_out   = col_out_q;
    assign key_hex   = key_hex_q;
    assign key_valid = key_valid_q;
    assign key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//
// Directed bench for keypad_scanner with PRESCALER_BITS=2 (4-cycle dwell,
// 16-cycle frame) and DEBOUNCE_SCANS=3. A behavioural keypad pulls row r low
// while key (r,c) is pressed and column c is driven low. Keys are changed
// right at frame starts (first cycle of column 0 after column 3), so each
// frame sees one stable key pattern.
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_hex;
    logic        key_valid;
    logic        key_down;
    logic [15:0] keys;

    int checks      = 0;
    int failures    = 0;
    int pulse_count = 0;

    keypad_scanner #(
        .PRESCALER_BITS(2),
        .DEBOUNCE_SCANS(3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .row_in   (row_in),
        .col_out  (col_out),
        .key_hex  (key_hex),
        .key_valid(key_valid),
        .key_down (key_down)
    );

    always #5 clk = ~clk;

    // Keypad model: keys[r*4+c] is key code {r,c}
    always_comb begin
        row_in = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && (col_out[c] == 1'b0)) begin
                    row_in[r] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            pulse_count++;
        end
    end

    // Leaves the bench in the first post-reset cycle (prescaler 0, column 0).
    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Advances to the next frame start: the cycle where col_out returns to
    // 1110 from 0111. This is also the frame_done cycle of the prior frame.
    task automatic next_frame_start();
        logic [3:0] prev;
        int n;
        prev = col_out;
        n = 0;
        forever begin
            @(posedge clk);
            #1;
            n++;
            if (prev == 4'b0111 && col_out == 4'b1110) break;
            prev = col_out;
            if (n > 100) begin
                checks++;
                failures++;
                $display("[TB] FAIL frame_timeout col_out=%b after %0d cycles, required a frame start", col_out, n);
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp;
        keys = 16'h0000;
        do_reset();
        checks++;
        if (col_out !== 4'b1110) begin
            failures++;
            $display("[TB] FAIL reset_col_out actual=%b required=%b", col_out, 4'b1110);
        end
        checks++;
        if (key_hex !== 4'h0) begin
            failures++;
            $display("[TB] FAIL reset_key_hex actual=%h required=%h", key_hex, 4'h0);
        end
        checks++;
        if (key_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_key_valid actual=%b required=%b", key_valid, 1'b0);
        end
        checks++;
        if (key_down !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_key_down actual=%b required=%b", key_down, 1'b0);
        end
        for (int i = 0; i < 20; i++) begin
            exp = ~(4'b0001 << ((i / 4) % 4));
            checks++;
            if (col_out !== exp) begin
                failures++;
                $display("[TB] FAIL scan_rotation cycle=%0d actual=%b required=%b", i, col_out, exp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_single_press();
        int base;
        keys = 16'h0000;
        do_reset();
        base = pulse_count;
        keys[9] = 1'b1;
        repeat (3) next_frame_start();
        checks++;
        if (pulse_count !== base) begin
            failures++;
            $display("[TB] FAIL single_early_pulse pulses=%0d required=%0d", pulse_count - base, 0);
        end
        checks++;
        if (key_down !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_early_down actual=%b required=%b", key_down, 1'b0);
        end
        @(posedge clk);
        #1;
        checks++;
        if (key_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL single_valid actual=%b required=%b", key_valid, 1'b1);
        end
        checks++;
        if (key_hex !== 4'h9) begin
            failures++;
            $display("[TB] FAIL single_key_hex actual=%h required=%h", key_hex, 4'h9);
        end
        checks++;
        if (key_down !== 1'b1) begin
            failures++;
            $display("[TB] FAIL single_key_down actual=%b required=%b", key_down, 1'b1);
        end
        @(posedge clk);
        #1;
        checks++;
        if (key_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_valid_width actual=%b required=%b", key_valid, 1'b0);
        end
        repeat (10) next_frame_start();
        checks++;
        if (pulse_count !== base + 1) begin
            failures++;
            $display("[TB] FAIL single_pulse_count pulses=%0d required=%0d", pulse_count - base, 1);
        end
        checks++;
        if (key_down !== 1'b1 || key_hex !== 4'h9) begin
            failures++;
            $display("[TB] FAIL single_hold down=%b hex=%h required down=1 hex=9", key_down, key_hex);
        end
    endtask

    task automatic test_bounce();
        int base;
        keys = 16'h0000;
        do_reset();
        base = pulse_count;
        keys[9] = 1'b1;
        next_frame_start();
        keys = 16'h0000;
        next_frame_start();
        keys[9] = 1'b1;
        repeat (3) next_frame_start();
        checks++;
        if (pulse_count !== base) begin
            failures++;
            $display("[TB] FAIL bounce_early_pulse pulses=%0d required=%0d", pulse_count - base, 0);
        end
        @(posedge clk);
        #1;
        checks++;
        if (key_valid !== 1'b1 || key_hex !== 4'h9) begin
            failures++;
            $display("[TB] FAIL bounce_accept valid=%b hex=%h required valid=1 hex=9", key_valid, key_hex);
        end
    endtask

    task automatic test_two_keys();
        int base;
        keys = 16'h0000;
        do_reset();
        base = pulse_count;
        keys[0] = 1'b1;
        keys[5] = 1'b1;
        repeat (4) next_frame_start();
        checks++;
        if (pulse_count !== base || key_down !== 1'b0) begin
            failures++;
            $display("[TB] FAIL two_keys_no_pulse pulses=%0d down=%b required pulses=0 down=0", pulse_count - base, key_down);
        end
        keys[0] = 1'b0;
        repeat (3) next_frame_start();
        checks++;
        if (pulse_count !== base) begin
            failures++;
            $display("[TB] FAIL two_keys_early_pulse pulses=%0d required=%0d", pulse_count - base, 0);
        end
        @(posedge clk);
        #1;
        checks++;
        if (key_valid !== 1'b1 || key_hex !== 4'h5) begin
            failures++;
            $display("[TB] FAIL two_keys_accept valid=%b hex=%h required valid=1 hex=5", key_valid, key_hex);
        end
    endtask

    task automatic test_release();
        int base;
        keys = 16'h0000;
        do_reset();
        base = pulse_count;
        keys[9] = 1'b1;
        repeat (3) next_frame_start();
        @(posedge clk);
        #1;
        checks++;
        if (key_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL release_press valid=%b required=%b", key_valid, 1'b1);
        end
        next_frame_start();
        keys = 16'h0000;
        next_frame_start();
        keys[9] = 1'b1;
        repeat (2) next_frame_start();
        checks++;
        if (key_down !== 1'b1 || pulse_count !== base + 1) begin
            failures++;
            $display("[TB] FAIL release_glitch down=%b pulses=%0d required down=1 pulses=1", key_down, pulse_count - base);
        end
        keys = 16'h0000;
        repeat (3) next_frame_start();
        checks++;
        if (key_down !== 1'b1) begin
            failures++;
            $display("[TB] FAIL release_early_fall actual=%b required=%b", key_down, 1'b1);
        end
        @(posedge clk);
        #1;
        checks++;
        if (key_down !== 1'b0) begin
            failures++;
            $display("[TB] FAIL release_fall actual=%b required=%b", key_down, 1'b0);
        end
        checks++;
        if (pulse_count !== base + 1 || key_hex !== 4'h9) begin
            failures++;
            $display("[TB] FAIL release_no_pulse pulses=%0d hex=%h required pulses=1 hex=9", pulse_count - base, key_hex);
        end
    endtask

    task automatic test_reset_mid_debounce();
        int base;
        keys = 16'h0000;
        do_reset();
        keys[9] = 1'b1;
        repeat (2) next_frame_start();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (col_out !== 4'b1110 || key_valid !== 1'b0 || key_down !== 1'b0 || key_hex !== 4'h0) begin
            failures++;
            $display("[TB] FAIL mid_reset_values col=%b valid=%b down=%b hex=%h required col=1110 valid=0 down=0 hex=0",
                     col_out, key_valid, key_down, key_hex);
        end
        base = pulse_count;
        repeat (3) next_frame_start();
        checks++;
        if (pulse_count !== base || key_down !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_reset_early pulses=%0d down=%b required pulses=0 down=0", pulse_count - base, key_down);
        end
        @(posedge clk);
        #1;
        checks++;
        if (key_valid !== 1'b1 || key_hex !== 4'h9) begin
            failures++;
            $display("[TB] FAIL mid_reset_accept valid=%b hex=%h required valid=1 hex=9", key_valid, key_hex);
        end
    endtask

    initial begin
        rst  = 1'b1;
        keys = 16'h0000;
        test_reset();
        test_single_press();
        test_bounce();
        test_two_keys();
        test_release();
        test_reset_mid_debounce();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
